// File: rtl/cmsdk_clock_gate_ctrl_pkg.sv
// Shared types and constants for the idle-driven clock-gating controller.
// Per-domain state encoding is fixed so it can be matched in debug views.
package cmsdk_clock_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_REQ    = 3'd2,
    ST_OFF    = 3'd3,
    ST_WAKEUP = 3'd4
  } dom_state_e;

  // Width of each per-domain gated-cycle statistics counter.
  localparam int GATEDCNT_W = 16;

endpackage

// File: rtl/cmsdk_clock_gate_ctrl_dom.sv
// One gated-clock domain: stop/wake FSM plus idle-hysteresis counter.
// Optional macro CMSDK_CLKCTRL_STATS_EN adds a saturating count of OFF cycles.
//
// state  | meaning
// RUN    | domain busy, clock on, counter held at 0
// IDLE   | domain idle, counting down the hysteresis window
// REQ    | stop requested, waiting for the domain to acknowledge
// OFF    | clock gated; ACTIVE/STOPACK ignored until WAKE or DISABLEG
// WAKEUP | clock back on, waiting for the domain to drop its ack
module cmsdk_clock_gate_ctrl_dom
  import cmsdk_clock_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic disable_g,
  input  logic active,
  input  logic wake,
  input  logic stop_ack,
  output logic stop_req,
  output logic clk_en,
  output logic sleeping
`ifdef CMSDK_CLKCTRL_STATS_EN
  ,
  output logic [GATEDCNT_W-1:0] gated_cnt
`endif
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IDLE_CYCLES - 1);

  dom_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_req_q, stop_req_d;
  logic             clk_en_q, clk_en_d;
  logic             sleeping_q, sleeping_d;

  // Next state and idle counter; DISABLEG wins over every other input.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        // Gating disabled means no idle progression at all.
        if (!disable_g && !active) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_IDLE: begin
        if (disable_g) begin
          state_d = ST_IDLE;
        end else if (active) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REQ: begin
        // A pending WAKE holds off the stop even if the domain acks.
        if (disable_g || active) begin
          state_d = ST_RUN;
        end else if (!wake && stop_ack) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (wake || disable_g) begin
          state_d = ST_WAKEUP;
        end
      end
      ST_WAKEUP: begin
        if (!stop_ack) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the state being entered so they register with it.
  always_comb begin
    stop_req_d = (state_d == ST_REQ) || (state_d == ST_OFF);
    clk_en_d   = (state_d != ST_OFF);
    sleeping_d = (state_d == ST_OFF);
  end

  // State, counter and registered outputs; reset returns clocks on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      stop_req_q <= 1'b0;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_req_q <= stop_req_d;
      clk_en_q   <= clk_en_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign stop_req = stop_req_q;
  assign clk_en   = clk_en_q;
  assign sleeping = sleeping_q;

`ifdef CMSDK_CLKCTRL_STATS_EN
  logic [GATEDCNT_W-1:0] gated_cnt_q, gated_cnt_d;

  // Count cycles spent gated, holding at all-ones instead of wrapping.
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if ((state_q == ST_OFF) && (gated_cnt_q != '1)) begin
      gated_cnt_d = gated_cnt_q + GATEDCNT_W'(1);
    end
  end

  // Statistics counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gated_cnt_q <= '0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign gated_cnt = gated_cnt_q;
`endif

endmodule

// File: rtl/cmsdk_clock_gate_ctrl.sv
// Idle-driven clock-gating controller for NUM_DOMAINS gated clock domains.
// Drives the CLKENABLE input of external gate cells; DISABLEG forces all on.
// Optional macro CMSDK_CLKCTRL_STATS_EN adds the GATEDCNT statistics port.
module cmsdk_clock_gate_ctrl
  import cmsdk_clock_gate_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   DISABLEG,
  input  logic [NUM_DOMAINS-1:0] ACTIVE,
  input  logic [NUM_DOMAINS-1:0] WAKE,
  input  logic [NUM_DOMAINS-1:0] STOPACK,
  output logic [NUM_DOMAINS-1:0] STOPREQ,
  output logic [NUM_DOMAINS-1:0] CLKENABLE,
  output logic [NUM_DOMAINS-1:0] SLEEPING
`ifdef CMSDK_CLKCTRL_STATS_EN
  ,
  output logic [NUM_DOMAINS*GATEDCNT_W-1:0] GATEDCNT
`endif
);

  logic [NUM_DOMAINS-1:0] clk_en_reg;

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    cmsdk_clock_gate_ctrl_dom #(
      .IDLE_CYCLES (IDLE_CYCLES)
    ) u_dom (
      .clk       (CLK),
      .rst       (RESET),
      .disable_g (DISABLEG),
      .active    (ACTIVE[i]),
      .wake      (WAKE[i]),
      .stop_ack  (STOPACK[i]),
      .stop_req  (STOPREQ[i]),
      .clk_en    (clk_en_reg[i]),
      .sleeping  (SLEEPING[i])
`ifdef CMSDK_CLKCTRL_STATS_EN
      ,
      .gated_cnt (GATEDCNT[i*GATEDCNT_W +: GATEDCNT_W])
`endif
    );
  end

  // DISABLEG bypasses the registered enable so scan/debug gets clocks at once.
  assign CLKENABLE = clk_en_reg | {NUM_DOMAINS{DISABLEG}};

endmodule

// File: tb/tb_cmsdk_clock_gate_ctrl.sv
// Directed bench for cmsdk_clock_gate_ctrl (NUM_DOMAINS=4, IDLE_CYCLES=16).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_cmsdk_clock_gate_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DISABLEG;
  logic [3:0] ACTIVE;
  logic [3:0] WAKE;
  logic [3:0] STOPACK;
  logic [3:0] STOPREQ;
  logic [3:0] CLKENABLE;
  logic [3:0] SLEEPING;
`ifdef CMSDK_CLKCTRL_STATS_EN
  logic [63:0] GATEDCNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  cmsdk_clock_gate_ctrl #(
    .NUM_DOMAINS (4),
    .IDLE_CYCLES (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DISABLEG  (DISABLEG),
    .ACTIVE    (ACTIVE),
    .WAKE      (WAKE),
    .STOPACK   (STOPACK),
    .STOPREQ   (STOPREQ),
    .CLKENABLE (CLKENABLE),
    .SLEEPING  (SLEEPING)
`ifdef CMSDK_CLKCTRL_STATS_EN
    ,
    .GATEDCNT  (GATEDCNT)
`endif
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; DISABLEG = 1'b0; ACTIVE = 4'hF; WAKE = 4'h0; STOPACK = 4'h0;
    tick(2);
    check("rst_en",    16'(CLKENABLE), 16'hF);
    check("rst_req",   16'(STOPREQ),   16'h0);
    check("rst_sleep", 16'(SLEEPING),  16'h0);
    RESET = 1'b0;
    tick(2);
    check("run_en", 16'(CLKENABLE), 16'hF);

    // Domain 0 idles: request exactly 1+IDLE_CYCLES edges after the drop.
    ACTIVE = 4'hE;
    tick(16);
    check("d0_req_early", 16'(STOPREQ), 16'h0);
    tick(1);
    check("d0_req",    16'(STOPREQ),   16'h1);
    check("d0_req_en", 16'(CLKENABLE), 16'hF);
    STOPACK = 4'h1;
    tick(1);
    check("d0_off_en",    16'(CLKENABLE), 16'hE);
    check("d0_off_sleep", 16'(SLEEPING),  16'h1);
    ACTIVE = 4'hF;
    tick(2);
    check("d0_frozen", 16'(CLKENABLE), 16'hE);
    ACTIVE = 4'hE;

    // Domain 1 goes busy again at count 5: back to RUN, never requests.
    ACTIVE = 4'hC;
    tick(11);
    ACTIVE = 4'hE;
    tick(11);
    check("d1_abort_idle", 16'(STOPREQ), 16'h1);

    // Domain 1 in REQ sees ACTIVE and STOPACK together: ACTIVE wins.
    ACTIVE = 4'hC;
    tick(17);
    check("d1_req", 16'(STOPREQ), 16'h3);
    ACTIVE = 4'hE; STOPACK = 4'h3;
    tick(1);
    check("d1_abort_req", 16'(STOPREQ),   16'h1);
    check("d1_abort_en",  16'(CLKENABLE), 16'hE);
    tick(2);
    check("d1_ack_in_run", 16'(SLEEPING), 16'h1);
    STOPACK = 4'h1;

    // Domain 2 in REQ: WAKE holds off an ack, then the stop completes.
    ACTIVE = 4'hA;
    tick(17);
    check("d2_req", 16'(STOPREQ), 16'h5);
    WAKE = 4'h4; STOPACK = 4'h5;
    tick(1);
    check("d2_wake_over_ack", 16'(SLEEPING), 16'h1);
    WAKE = 4'h0;
    tick(1);
    check("d2_off", 16'(SLEEPING), 16'h5);
    check("d2_off_en", 16'(CLKENABLE), 16'hA);

    // Wake domain 2: clock on next edge, stays in WAKEUP while ack held.
    WAKE = 4'h4;
    tick(1);
    check("d2_wake_en",  16'(CLKENABLE), 16'hE);
    check("d2_wake_req", 16'(STOPREQ),   16'h1);
    WAKE = 4'h0;
    tick(2);
    check("d2_wakeup_hold", 16'(CLKENABLE), 16'hE);
    STOPACK = 4'h1;
    tick(17);
    check("d2_run_idle", 16'(STOPREQ), 16'h1);
    tick(1);
    check("d2_rereq", 16'(STOPREQ), 16'h5);

    // Put every domain to sleep, then force clocks on with DISABLEG.
    ACTIVE = 4'h0; STOPACK = 4'hF;
    tick(18);
    check("all_off_sleep", 16'(SLEEPING),  16'hF);
    check("all_off_en",    16'(CLKENABLE), 16'h0);
    DISABLEG = 1'b1;
    #1;
    check("dis_comb_en", 16'(CLKENABLE), 16'hF);
    tick(1);
    check("dis_wakeup_sleep", 16'(SLEEPING), 16'h0);
    check("dis_wakeup_req",   16'(STOPREQ),  16'h0);
    STOPACK = 4'h0;
    tick(20);
    check("dis_no_req", 16'(STOPREQ), 16'h0);
    DISABLEG = 1'b0;
    tick(16);
    check("dis_rel_early", 16'(STOPREQ), 16'h0);
    tick(1);
    check("dis_rel_req", 16'(STOPREQ), 16'hF);
    DISABLEG = 1'b1;
    tick(1);
    check("dis_req_to_run", 16'(STOPREQ), 16'h0);

    // IDLE count frozen while DISABLEG is set.
    DISABLEG = 1'b0;
    tick(5);
    DISABLEG = 1'b1;
    tick(10);
    DISABLEG = 1'b0;
    tick(11);
    check("freeze_early", 16'(STOPREQ), 16'h0);
    tick(1);
    check("freeze_req", 16'(STOPREQ), 16'hF);

    // Asynchronous reset in the middle of a stop.
    STOPACK = 4'hF;
    tick(1);
    check("pre_rst_sleep", 16'(SLEEPING), 16'hF);
    RESET = 1'b1;
    #1;
    check("arst_en",    16'(CLKENABLE), 16'hF);
    check("arst_req",   16'(STOPREQ),   16'h0);
    check("arst_sleep", 16'(SLEEPING),  16'h0);
    tick(1);
    RESET = 1'b0; STOPACK = 4'h0; ACTIVE = 4'hF;
    tick(2);
    check("post_rst_en", 16'(CLKENABLE), 16'hF);

`ifdef CMSDK_CLKCTRL_STATS_EN
    ACTIVE = 4'h7; STOPACK = 4'h8;
    tick(18);
    check("st_d3_off", 16'(SLEEPING), 16'h8);
    tick(5);
    check("st_cnt5", GATEDCNT[63:48], 16'd5);
    tick(70000);
    check("st_sat",  GATEDCNT[63:48], 16'hFFFF);
    check("st_d0",   GATEDCNT[15:0],  16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
